demod_demapper: RTL and testbench

// Hard-decision demapper, the receive-side inverse of the modulation mapper. Takes one

---
 rtl/demod_demapper.sv | 153 +++++++++++++++
 tb/tb_demod_demapper.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demod_demapper.sv
// rtl/demod_demapper.sv - hard-decision QPSK/16QAM/64QAM demapper with serial bit output
module demod_demapper #(
    parameter int LUT_WIDTH = 18,
    parameter int THR_16    = 20724,
    parameter int THR_64_1  = 10112,
    parameter int THR_64_2  = 20225,
    parameter int THR_64_3  = 30337
) (
    input  logic                 CLK_Demod,
    input  logic                 RST_Demod,
    input  logic                 Valid_Demod_IN,
    input  logic [LUT_WIDTH-1:0] Demod_IN_I,
    input  logic [LUT_WIDTH-1:0] Demod_IN_Q,
    input  logic [2:0]           Order_Demod,
    input  logic                 Last_Demod_IN,
    output logic                 Ready_Demod,
    output logic                 Serial_OUT,
    output logic                 Valid_Demod_OUT,
    output logic                 DEMOD_DONE,
    output logic [15:0]          Bit_Count
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    // Thresholds widened to the |x| width so the most negative sample compares correctly
    localparam logic [LUT_WIDTH:0] T16  = (LUT_WIDTH+1)'(THR_16);
    localparam logic [LUT_WIDTH:0] T641 = (LUT_WIDTH+1)'(THR_64_1);
    localparam logic [LUT_WIDTH:0] T642 = (LUT_WIDTH+1)'(THR_64_2);
    localparam logic [LUT_WIDTH:0] T643 = (LUT_WIDTH+1)'(THR_64_3);

    logic [0:0]         state_q, state_d;
    logic [5:0]         sr_q, sr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               ser_q, ser_d;
    logic               val_q, val_d;
    logic               done_q, done_d;
    logic [15:0]        bc_q, bc_d;

    logic [LUT_WIDTH:0] ext_i, ext_q, abs_i, abs_q;
    logic               sgn_i, sgn_q;
    logic [5:0]         slice_bits;
    logic [2:0]         slice_n;
    logic               slice_ok;
    logic               accept, final_bit;
    logic [15:0]        bc_base;

    assign sgn_i = Demod_IN_I[LUT_WIDTH-1];
    assign sgn_q = Demod_IN_Q[LUT_WIDTH-1];
    assign ext_i = {sgn_i, Demod_IN_I};
    assign ext_q = {sgn_q, Demod_IN_Q};
    assign abs_i = sgn_i ? -ext_i : ext_i;
    assign abs_q = sgn_q ? -ext_q : ext_q;

    assign final_bit   = (state_q == S_SHIFT) && (cnt_q == 3'd1);
    assign Ready_Demod = (state_q == S_IDLE) || final_bit;
    assign accept      = Valid_Demod_IN && Ready_Demod;

    // Slice the current input symbol into bits, b0 in the MSB position
    always_comb begin
        slice_bits = 6'b0;
        slice_n    = 3'd0;
        slice_ok   = 1'b0;
        case (Order_Demod)
            3'd1: begin
                slice_bits = {sgn_i, sgn_q, 4'b0};
                slice_n    = 3'd2;
                slice_ok   = 1'b1;
            end
            3'd2: begin
                slice_bits = {sgn_i, sgn_q, abs_i > T16, abs_q > T16, 2'b0};
                slice_n    = 3'd4;
                slice_ok   = 1'b1;
            end
            3'd3: begin
                slice_bits = {sgn_i, sgn_q, abs_i > T642, abs_q > T642,
                              (abs_i <= T641) || (abs_i > T643),
                              (abs_q <= T641) || (abs_q > T643)};
                slice_n    = 3'd6;
                slice_ok   = 1'b1;
            end
            default: begin
                slice_bits = 6'b0;
                slice_n    = 3'd0;
                slice_ok   = 1'b0;
            end
        endcase
    end

    // Next-state: shift out, finish a symbol, or load a newly accepted one
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ser_d   = ser_q;
        val_d   = val_q;
        done_d  = 1'b0;
        if (state_q == S_SHIFT && cnt_q > 3'd1) begin
            ser_d = sr_q[5];
            sr_d  = {sr_q[4:0], 1'b0};
            cnt_d = cnt_q - 3'd1;
            val_d = 1'b1;
        end
        if (final_bit) begin
            done_d  = last_q;
            state_d = S_IDLE;
            ser_d   = 1'b0;
            val_d   = 1'b0;
        end
        // An accept on the final bit overrides the return to idle, giving no bubble
        if (accept && slice_ok) begin
            ser_d   = slice_bits[5];
            sr_d    = {slice_bits[4:0], 1'b0};
            cnt_d   = slice_n;
            last_d  = Last_Demod_IN;
            val_d   = 1'b1;
            state_d = S_SHIFT;
        end
        bc_base = done_d ? 16'd0 : bc_q;
        bc_d    = (val_d && bc_base != 16'hFFFF) ? bc_base + 16'd1 : bc_base;
    end

    // State and output registers
    always_ff @(posedge CLK_Demod or negedge RST_Demod) begin
        if (!RST_Demod) begin
            state_q <= S_IDLE;
            sr_q    <= 6'b0;
            cnt_q   <= 3'd0;
            last_q  <= 1'b0;
            ser_q   <= 1'b0;
            val_q   <= 1'b0;
            done_q  <= 1'b0;
            bc_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ser_q   <= ser_d;
            val_q   <= val_d;
            done_q  <= done_d;
            bc_q    <= bc_d;
        end
    end

    assign Serial_OUT      = ser_q;
    assign Valid_Demod_OUT = val_q;
    assign DEMOD_DONE      = done_q;
    assign Bit_Count       = bc_q;

endmodule

// File: tb/tb_demod_demapper.sv
// tb/tb_demod_demapper.sv - table-driven scoreboard bench for demod_demapper
module tb_demod_demapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vin;
    logic [17:0] din_i, din_q;
    logic [2:0]  order;
    logic        last_in;
    logic        ready, ser, vout, done;
    logic [15:0] bcount;

    demod_demapper dut (
        .CLK_Demod      (clk),
        .RST_Demod      (rst_n),
        .Valid_Demod_IN (vin),
        .Demod_IN_I     (din_i),
        .Demod_IN_Q     (din_q),
        .Order_Demod    (order),
        .Last_Demod_IN  (last_in),
        .Ready_Demod    (ready),
        .Serial_OUT     (ser),
        .Valid_Demod_OUT(vout),
        .DEMOD_DONE     (done),
        .Bit_Count      (bcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] order;
        int         i;
        int         q;
        logic       last;
        logic [5:0] exp;
        int         n;
    } vec_t;

    typedef struct {
        logic b;
        logic fin;
        logic flast;
    } bit_t;

    vec_t vecs[10];
    bit_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_done_next = 1'b0;
    int   cnt_m = 0;
    int   run_len = 0;
    int   max_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops expected bits and checks ready, done and bit count every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_done_next = 1'b0;
            cnt_m = 0;
            run_len = 0;
        end else begin
            bit_t e;
            logic done_now;
            done_now = exp_done_next;
            chk("done", {31'b0, done}, {31'b0, done_now});
            if (vout) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                    exp_done_next = 1'b0;
                end else begin
                    e = sb.pop_front();
                    chk("serial", {31'b0, ser}, {31'b0, e.b});
                    chk("ready_busy", {31'b0, ready}, {31'b0, e.fin});
                    exp_done_next = e.fin && e.flast;
                end
            end else begin
                run_len = 0;
                chk("ready_idle", {31'b0, ready}, 32'd1);
                exp_done_next = 1'b0;
            end
            if (done_now) cnt_m = 0;
            if (vout && cnt_m < 65535) cnt_m++;
            chk("bit_count", {16'b0, bcount}, cnt_m);
        end
    end

    task automatic go_idle();
        vin     = 1'b0;
        din_i   = 18'($urandom);
        din_q   = 18'($urandom);
        order   = 3'($urandom);
        last_in = 1'b0;
    endtask

    // Drive one symbol and hold it until accepted; expected bits enter the scoreboard
    task automatic send(input vec_t v);
        int waited;
        @(negedge clk);
        vin     = 1'b1;
        din_i   = 18'(v.i);
        din_q   = 18'(v.q);
        order   = v.order;
        last_in = v.last;
        waited  = 0;
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        for (int k = 0; k < v.n; k++) begin
            bit_t e;
            e.b     = v.exp[5-k];
            e.fin   = (k == v.n - 1);
            e.flast = v.last;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((sb.size() != 0 || vout || exp_done_next) && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("drain", {31'b0, sb.size() == 0 && !vout}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{3'd1,  23170,  -23170, 1'b0, 6'b010000, 2};
        vecs[1] = '{3'd2, -31086,   10362, 1'b0, 6'b101000, 4};
        vecs[2] = '{3'd2,  20724,  -20725, 1'b0, 6'b010100, 4};
        vecs[3] = '{3'd3,  35393,   -5056, 1'b1, 6'b011011, 6};
        vecs[4] = '{3'd3, -131072,  10112, 1'b0, 6'b101011, 6};
        vecs[5] = '{3'd3,  20225,  -20226, 1'b0, 6'b010100, 6};
        vecs[6] = '{3'd1,      0,      -1, 1'b0, 6'b010000, 2};
        vecs[7] = '{3'd3,  30337,   30338, 1'b0, 6'b001101, 6};
        vecs[8] = '{3'd7,  12345,  -12345, 1'b0, 6'b000000, 0};
        vecs[9] = '{3'd2, 131071, -131072, 1'b1, 6'b011100, 4};

        rst_n = 1'b0;
        go_idle();
        #22;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_valid", {31'b0, vout}, 32'd0);
        chk("rst_serial", {31'b0, ser}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_count", {16'b0, bcount}, 32'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            send(vecs[t]);
            go_idle();
            drain();
            repeat (2) @(posedge clk);
        end

        // Back-to-back mixed orders: 2+6+4 bits with no gap
        max_run = 0;
        send(vecs[0]);
        send(vecs[5]);
        send(vecs[1]);
        go_idle();
        drain();
        chk("contiguous_run", max_run, 32'd12);

        // Reset while the 3rd bit of a 64QAM symbol is on the output
        begin
            vec_t r;
            r = vecs[3];
            r.last = 1'b0;
            send(r);
            go_idle();
            @(posedge clk);
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("midrst_valid", {31'b0, vout}, 32'd0);
            chk("midrst_serial", {31'b0, ser}, 32'd0);
            chk("midrst_ready", {31'b0, ready}, 32'd1);
            chk("midrst_count", {16'b0, bcount}, 32'd0);
            @(posedge clk);
            #2;
            rst_n = 1'b1;
        end
        send(vecs[7]);
        go_idle();
        drain();
        send(vecs[3]);
        go_idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
